// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared types and pair-count helpers for the pulse generator / coincidence detector
package detector_pkg;

    // Pulse generator sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    // Number of distinct channel pairs the detector tracks
    function automatic int npairs(input int nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

    // Expected coincidence count for one channel pair over a whole run.
    // Each channel is high over [offset, min(offset+width, period)) in every
    // period; the pair coincides once per period when those intervals overlap.
    function automatic int exp_pair_count(
        input bit en_a,
        input bit en_b,
        input int off_a,
        input int off_b,
        input int width,
        input int period,
        input int npulses
    );
        int end_a;
        int end_b;
        int lo;
        int hi;
        end_a = (off_a + width < period) ? off_a + width : period;
        end_b = (off_b + width < period) ? off_b + width : period;
        lo    = (off_a > off_b) ? off_a : off_b;
        hi    = (end_a < end_b) ? end_a : end_b;
        if (!en_a || !en_b)          return 0;
        if (off_a >= end_a)          return 0;
        if (off_b >= end_b)          return 0;
        if (lo >= hi)                return 0;
        return npulses;
    endfunction

endpackage

// File: rtl/pulse_shaper.sv
// rtl/pulse_shaper.sv - one channel's phase window compare with a registered output
module pulse_shaper
    import detector_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             en_i,
    input  logic             mask_i,
    input  logic [NBITS-1:0] phase_i,
    input  logic [NBITS-1:0] offset_i,
    input  logic [NBITS-1:0] width_i,
    output logic             pulse_o
);

    logic             pulse_q;
    logic             pulse_d;
    logic [NBITS:0]   phase_x;
    logic [NBITS:0]   start_x;
    logic [NBITS:0]   stop_x;

    // Window test in NBITS+1 bits so offset+width cannot wrap; since the
    // phase never reaches the period, the window truncates at period end
    // and an offset at or beyond the period never matches.
    always_comb begin
        phase_x = {1'b0, phase_i};
        start_x = {1'b0, offset_i};
        stop_x  = start_x + {1'b0, width_i};
        pulse_d = en_i && mask_i && (phase_x >= start_x) && (phase_x < stop_x);
    end

    // Output register: one stage of latency after the phase
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - programmable multi-channel pulse-pattern transmitter
module pulse_generator
    import detector_pkg::*;
#(
    parameter int NCHAN = 4,
    parameter int NBITS = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start_i,
    input  logic             Abort_i,
    input  logic [NBITS-1:0] Period_i,
    input  logic [NBITS-1:0] Width_i,
    input  logic [NBITS-1:0] Offsets_i [NCHAN],
    input  logic [NCHAN-1:0] ChanMask_i,
    input  logic [NBITS-1:0] nPulses_i,
    output logic [NCHAN-1:0] Channels_o,
    output logic             Sync_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Err_o,
    output logic [NBITS-1:0] PulseCnt_o
);

    gen_state_t       state_q;
    gen_state_t       state_d;
    logic [NBITS-1:0] phase_q;
    logic [NBITS-1:0] phase_d;
    logic [NBITS-1:0] cnt_q;
    logic [NBITS-1:0] cnt_d;
    logic [NBITS-1:0] cnt_inc;

    // Shadow copy of the run configuration, frozen for the whole run
    logic [NBITS-1:0] period_q;
    logic [NBITS-1:0] period_d;
    logic [NBITS-1:0] width_q;
    logic [NBITS-1:0] width_d;
    logic [NBITS-1:0] npulses_q;
    logic [NBITS-1:0] npulses_d;
    logic [NCHAN-1:0] mask_q;
    logic [NCHAN-1:0] mask_d;
    logic [NBITS-1:0] offsets_q [NCHAN];
    logic [NBITS-1:0] offsets_d [NCHAN];

    // Single-cycle flags, registered so they line up with Channels_o
    logic             sync_q;
    logic             sync_d;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;

    logic             shaper_en;
    logic [NCHAN-1:0] chan_pulse;

    // Next-state, phase/count sequencing and configuration capture
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        width_d   = width_q;
        npulses_d = npulses_q;
        mask_d    = mask_q;
        for (int i = 0; i < NCHAN; i++) begin
            offsets_d[i] = offsets_q[i];
        end
        sync_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_inc   = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                // Abort beats a simultaneous start
                if (Start_i && !Abort_i) begin
                    if (Period_i == '0) begin
                        err_d = 1'b1;
                    end else if (nPulses_i == '0) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        period_d  = Period_i;
                        width_d   = Width_i;
                        npulses_d = nPulses_i;
                        mask_d    = ChanMask_i;
                        for (int i = 0; i < NCHAN; i++) begin
                            offsets_d[i] = Offsets_i[i];
                        end
                        cnt_d   = '0;
                        phase_d = '0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (Abort_i) begin
                    // Count is left as-is so software can see how far it got
                    phase_d = '0;
                    state_d = IDLE;
                end else begin
                    sync_d = (phase_q == '0);
                    if (phase_q == period_q - 1'b1) begin
                        phase_d = '0;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == npulses_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end

            DONE: begin
                done_d  = !Abort_i;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, phase, count and flag registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shadow configuration registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            period_q  <= '0;
            width_q   <= '0;
            npulses_q <= '0;
            mask_q    <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                offsets_q[i] <= '0;
            end
        end else begin
            period_q  <= period_d;
            width_q   <= width_d;
            npulses_q <= npulses_d;
            mask_q    <= mask_d;
            for (int i = 0; i < NCHAN; i++) begin
                offsets_q[i] <= offsets_d[i];
            end
        end
    end

    // An abort clears the channel registers on the same edge it leaves RUN
    assign shaper_en = (state_q == RUN) && !Abort_i;

    generate
        for (genvar g = 0; g < NCHAN; g++) begin : g_chan
            pulse_shaper #(
                .NBITS (NBITS)
            ) u_shaper (
                .Clk      (Clk),
                .Rst_n    (Rst_n),
                .en_i     (shaper_en),
                .mask_i   (mask_q[g]),
                .phase_i  (phase_q),
                .offset_i (offsets_q[g]),
                .width_i  (width_q),
                .pulse_o  (chan_pulse[g])
            );
        end
    endgenerate

    assign Channels_o = chan_pulse;
    assign Sync_o     = sync_q;
    assign Done_o     = done_q;
    assign Err_o      = err_q;
    assign Busy_o     = (state_q != IDLE);
    assign PulseCnt_o = cnt_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - self-checking bench for pulse_generator
module tb_pulse_generator;
    import detector_pkg::*;

    localparam int NCHAN = 4;
    localparam int NBITS = 4;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             Start_i;
    logic             Abort_i;
    logic [NBITS-1:0] Period_i;
    logic [NBITS-1:0] Width_i;
    logic [NBITS-1:0] offsets [NCHAN];
    logic [NCHAN-1:0] ChanMask_i;
    logic [NBITS-1:0] nPulses_i;
    logic [NCHAN-1:0] Channels_o;
    logic             Sync_o;
    logic             Busy_o;
    logic             Done_o;
    logic             Err_o;
    logic [NBITS-1:0] PulseCnt_o;

    pulse_generator #(
        .NCHAN (NCHAN),
        .NBITS (NBITS)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start_i    (Start_i),
        .Abort_i    (Abort_i),
        .Period_i   (Period_i),
        .Width_i    (Width_i),
        .Offsets_i  (offsets),
        .ChanMask_i (ChanMask_i),
        .nPulses_i  (nPulses_i),
        .Channels_o (Channels_o),
        .Sync_o     (Sync_o),
        .Busy_o     (Busy_o),
        .Done_o     (Done_o),
        .Err_o      (Err_o),
        .PulseCnt_o (PulseCnt_o)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] ch;
        logic       sync;
        logic       done;
        logic       err;
        logic       busy;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        int             period;
        int             width;
        logic [3:0][3:0] off;
        logic [3:0]     mask;
        int             npulses;
        int             abort_at;
        bit             perturb;
        bit             pairs;
    } vec_t;

    vec_t vecs [9];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int p, input int w, input int o0, input int o1,
                                input int o2, input int o3, input logic [3:0] m,
                                input int n, input int ab, input bit pt, input bit pr);
        vec_t v;
        v.period   = p;
        v.width    = w;
        v.off[0]   = 4'(o0);
        v.off[1]   = 4'(o1);
        v.off[2]   = 4'(o2);
        v.off[3]   = 4'(o3);
        v.mask     = m;
        v.npulses  = n;
        v.abort_at = ab;
        v.perturb  = pt;
        v.pairs    = pr;
        return v;
    endfunction

    // Completed periods visible in cycle k (k=1 is the cycle after the start edge)
    function automatic int cnt_at(input vec_t v, input int k);
        int c;
        c = (k - 1) / v.period;
        if (c > v.npulses) c = v.npulses;
        return c;
    endfunction

    // Expected outputs in cycle k: RUN occupies cycles 1..P*N, DONE cycle P*N+1,
    // and registered outputs show the state/phase of the previous cycle.
    function automatic exp_t model(input vec_t v, input int k);
        exp_t e;
        int   total;
        int   ph;
        e     = '0;
        total = v.period * v.npulses;
        if (v.abort_at >= 0 && k > v.abort_at) begin
            e.cnt = 4'(cnt_at(v, v.abort_at));
            return e;
        end
        e.busy = (k >= 1) && (k <= total + 1);
        e.done = (k == total + 2);
        e.cnt  = 4'(cnt_at(v, k));
        if (k >= 2 && k - 1 <= total) begin
            ph     = (k - 2) % v.period;
            e.sync = (ph == 0);
            for (int i = 0; i < 4; i++) begin
                e.ch[i] = v.mask[i] && (ph >= int'(v.off[i])) && (ph < int'(v.off[i]) + v.width);
            end
        end
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.ch   = Channels_o;
        a.sync = Sync_o;
        a.done = Done_o;
        a.err  = Err_o;
        a.busy = Busy_o;
        a.cnt  = PulseCnt_o;
        return a;
    endfunction

    task automatic check_rec(input string name, input exp_t act, input exp_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got ch=%b sync=%b done=%b err=%b busy=%b cnt=%0d, want ch=%b sync=%b done=%b err=%b busy=%b cnt=%0d",
                     name, act.ch, act.sync, act.done, act.err, act.busy, act.cnt,
                     exp.ch, exp.sync, exp.done, exp.err, exp.busy, exp.cnt);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t act;
        int   total;
        int   len;
        int   p;
        int   pc [6];
        bit   pb [6];
        v     = vecs[idx];
        total = v.period * v.npulses;
        len   = total + 3;
        for (int i = 0; i < 6; i++) begin
            pc[i] = 0;
            pb[i] = 1'b0;
        end
        @(negedge Clk);
        Period_i   = 4'(v.period);
        Width_i    = 4'(v.width);
        ChanMask_i = v.mask;
        nPulses_i  = 4'(v.npulses);
        for (int i = 0; i < 4; i++) offsets[i] = v.off[i];
        Start_i    = 1'b1;
        for (int k = 1; k <= len; k++) sb.push_back(model(v, k));
        for (int k = 1; k <= len; k++) begin
            @(negedge Clk);
            Start_i = 1'b0;
            Abort_i = 1'b0;
            act = sample();
            check_rec($sformatf("vec%0d_cyc%0d", idx, k), act, sb.pop_front());
            p = 0;
            for (int a = 0; a < NCHAN; a++) begin
                for (int b = a + 1; b < NCHAN; b++) begin
                    if (Channels_o[a] && Channels_o[b] && !pb[p]) pc[p]++;
                    pb[p] = Channels_o[a] && Channels_o[b];
                    p++;
                end
            end
            if (k == v.abort_at) Abort_i = 1'b1;
            if (v.perturb && k >= 2 && k <= total) begin
                Start_i    = 1'($urandom_range(0, 1));
                Period_i   = 4'($urandom_range(0, 15));
                Width_i    = 4'($urandom_range(0, 15));
                ChanMask_i = 4'($urandom_range(0, 15));
                nPulses_i  = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++) offsets[i] = 4'($urandom_range(0, 15));
            end
        end
        if (v.pairs) begin
            p = 0;
            for (int a = 0; a < NCHAN; a++) begin
                for (int b = a + 1; b < NCHAN; b++) begin
                    check_int($sformatf("vec%0d_pair%0d%0d", idx, a, b), pc[p],
                              exp_pair_count(v.mask[a], v.mask[b], int'(v.off[a]), int'(v.off[b]),
                                             v.width, v.period, v.npulses));
                    p++;
                end
            end
            check_int($sformatf("vec%0d_npairs", idx), p, 6);
        end
    endtask

    initial begin
        exp_t e;
        Rst_n      = 1'b0;
        Start_i    = 1'b0;
        Abort_i    = 1'b0;
        Period_i   = '0;
        Width_i    = '0;
        ChanMask_i = '0;
        nPulses_i  = '0;
        for (int i = 0; i < NCHAN; i++) offsets[i] = '0;

        //          P   W   o0  o1  o2 o3  mask     N  abort pert pairs
        vecs[0] = mk(5,  2,  0,  1,  2, 3, 4'b1111, 0, -1,   0,   0);
        vecs[1] = mk(8,  2,  0,  0,  4, 4, 4'b1111, 3, -1,   0,   1);
        vecs[2] = mk(6,  5,  3,  7,  0, 5, 4'b1111, 2, -1,   0,   0);
        vecs[3] = mk(4,  0,  0,  1,  2, 3, 4'b1111, 2, -1,   0,   0);
        vecs[4] = mk(8,  2,  0,  0,  4, 4, 4'b1111, 3, 10,   0,   0);
        vecs[5] = mk(8,  2,  0,  0,  4, 4, 4'b1111, 3, -1,   1,   1);
        vecs[6] = mk(5,  3,  0,  1,  2, 4, 4'b0101, 2, -1,   0,   0);
        vecs[7] = mk(1,  1,  0,  0,  1, 0, 4'b1111, 3, -1,   0,   0);
        vecs[8] = mk(15, 15, 15, 14, 0, 1, 4'b1111, 1, -1,   0,   0);

        repeat (2) @(negedge Clk);
        check_rec("reset_state", sample(), '0);
        Rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Rejected start: Err_o for one cycle, never busy, count held
        @(negedge Clk);
        Period_i  = '0;
        nPulses_i = 4'd3;
        Start_i   = 1'b1;
        e = '0; e.err = 1'b1; e.cnt = 4'(vecs[8].npulses);
        @(negedge Clk);
        Start_i = 1'b0;
        check_rec("err_pulse", sample(), e);
        e.err = 1'b0;
        @(negedge Clk);
        check_rec("err_cleared", sample(), e);

        // Abort together with start in IDLE: start refused
        Period_i = 4'd4;
        Width_i  = 4'd2;
        Start_i  = 1'b1;
        Abort_i  = 1'b1;
        @(negedge Clk);
        Start_i = 1'b0;
        Abort_i = 1'b0;
        check_rec("abort_beats_start", sample(), e);
        repeat (3) @(negedge Clk);
        check_rec("abort_beats_start_later", sample(), e);

        // Asynchronous reset in the middle of a pulse
        Period_i   = 4'd8;
        Width_i    = 4'd2;
        ChanMask_i = 4'b1111;
        nPulses_i  = 4'd3;
        offsets[0] = 4'd0; offsets[1] = 4'd0; offsets[2] = 4'd4; offsets[3] = 4'd4;
        Start_i    = 1'b1;
        @(negedge Clk);
        Start_i = 1'b0;
        @(negedge Clk);
        e = '0; e.ch = 4'b0011; e.sync = 1'b1; e.busy = 1'b1;
        check_rec("pre_reset_pulse", sample(), e);
        #1 Rst_n = 1'b0;
        #1 check_rec("async_reset", sample(), '0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_rec("post_reset_idle", sample(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
Programmable multi-channel pulse-pattern transmitter. It drives the Channels input of the coincidence detector with repeatable, known patterns for self-test and calibration. Each period, every enabled channel emits one pulse at a per-channel phase offset with a common width, for a programmed number of periods. Because the coincidence pattern is set by the offsets, expected per-channel and pair counts are known exactly.

Parameters:
NCHAN, 4, number of output channels
NBITS, 4, width of period, width, offset and pulse-count fields

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Start_i  in  1  start request; sampled only in IDLE
Abort_i  in  1  abort request; stops a run
Period_i  in  NBITS  clocks per period; 0 is illegal
Width_i  in  NBITS  pulse high time in clocks
Offsets_i  in  NBITS x NCHAN (unpacked)  per-channel pulse start phase
ChanMask_i  in  NCHAN  1 = channel enabled
nPulses_i  in  NBITS  number of periods to emit
Channels_o  out  NCHAN  registered pulse outputs (to detector Channels)
Sync_o  out  1  one-cycle marker aligned with phase 0 of every period
Busy_o  out  1  high while not IDLE
Done_o  out  1  one-cycle pulse at normal completion
Err_o  out  1  one-cycle pulse when a start is rejected
PulseCnt_o  out  NBITS  completed periods in the current/last run

Behaviour:
- Reset (async, Rst_n low): state IDLE; Channels_o=0, Sync_o=0, Busy_o=0, Done_o=0, Err_o=0, PulseCnt_o=0; phase counter and shadow registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, Start_i=1, Period_i=0: reject; Err_o=1 next cycle; stay IDLE.
- IDLE, Start_i=1, Period_i!=0, nPulses_i=0: go to DONE; no pulses emitted.
- IDLE, Start_i=1, otherwise: latch Period, Width, Offsets, Mask and nPulses into shadow registers; clear PulseCnt_o; go to RUN with Phase=0.
- Inputs changing during RUN have no effect. Start_i is ignored outside IDLE.
- RUN: Phase counts 0..Period-1 and then wraps to 0. At Phase=Period-1, PulseCnt_o increments. If the new count equals nPulses, go to DONE.
- Channel i is asserted when all of these hold: Mask[i]=1; Phase >= Offset[i]; Phase < Offset[i]+Width.
  - The comparison is evaluated in NBITS+1 bits, so the sum never overflows.
  - A pulse truncates at the period end; it never wraps into the next period.
  - Offset[i] >= Period means the channel stays silent.
  - Width=0 means no pulses, but periods and PulseCnt_o still advance.
- Latency: with Start_i sampled at edge t, RUN Phase=0 holds in cycle t+1. Channels_o and Sync_o reflect that phase after edge t+2, so output latency is one register stage after the phase.
- DONE: lasts exactly one cycle. Done_o=1 and Channels_o=0 during it, then the block returns to IDLE. Busy_o=1 in RUN and DONE.
- Abort_i=1 in RUN or DONE: go to IDLE next edge and force Channels_o=0 in that same edge. Done_o is not asserted. PulseCnt_o holds its value.
- Abort_i and Start_i together in IDLE: Abort wins and the start is not accepted.
- Reset mid-run: immediate return to the reset values.
- PulseCnt_o holds its last value in IDLE until the next accepted start.

Decomposition:
- Shared package detector_pkg holds:
  - the gen_state_t enum {IDLE, RUN, DONE};
  - the function npairs(NCHAN) = NCHAN*(NCHAN-1)/2;
  - an expected-pair-count helper used by benches.
- One sub-module, pulse_shaper: per-channel compare of Phase against Offset/Width/Mask, with registered output. It is instantiated NCHAN times via generate.

Test Plan:
- Period=8, Width=2, Offsets={0,0,4,4}, Mask=4'b1111, nPulses=3 -> each channel gives 3 pulses of 2 clocks. Ch0/1 go high at phases 0-1 and ch2/3 at phases 4-5. Sync_o pulses 3 times, Done_o pulses once, PulseCnt_o=3. Looped into the detector, pairs (0,1)=3, (2,3)=3, all others 0.
- Period=6, Width=5, Offset[0]=3 -> ch0 is high at phases 3-5 only (truncated, 3 clocks). Offset[1]=7 -> ch1 stays silent.
- Start with Period_i=0 -> Err_o=1 for one cycle, Busy_o stays 0. Start with nPulses=0 -> Done_o after one cycle, Channels_o never asserted.
- Abort_i at cycle 10 of the first scenario -> Channels_o=0 and IDLE next cycle, no Done_o, PulseCnt_o=1.
- Rst_n low mid-pulse -> Channels_o and all flags 0 immediately (asynchronous). Start_i pulsed during RUN and config inputs changed mid-run -> waveform unchanged.
- Width=0, Period=4, nPulses=2 -> no channel activity, Sync_o twice, PulseCnt_o=2, Done_o once.
